s4_twiddle_combiner: RTL and testbench
======================================

Name: s4_twiddle_combiner

Overview:
Receive side of the stage-4 twiddle multiplier in the SDF FFT pipeline. Takes the four raw 28-bit partial products and the mode flag. Forms the complex product, rounds it back to s0.14 and saturates it. Presents a registered, valid-qualified sample to the stage-4 butterfly.
Two-cycle pipeline with a pipelined valid, bypass handling and a saturating overflow counter.

Parameters:
IN_W, 28, partial-product width (s2.25: 15-bit s0.14 data x 13-bit s1.11 twiddle)
OUT_W, 15, output sample width (s0.14)
FRAC_SHIFT, 11, twiddle fractional bits removed on requantization
OVF_W, 8, width of the overflow event counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  partial products and mode are valid this cycle
multi_stage  in  1  1 = twiddle multiply active, 0 = bypass (twiddle = 1)
multi_real  in  28  signed, data_re * tw_re
multi_imag  in  28  signed, data_im * tw_im
multi_real_imag_1  in  28  signed, data_re * tw_im
multi_real_imag_2  in  28  signed, data_im * tw_re
ovf_clr  in  1  synchronous clear of ovf_count
out_valid  out  1  out_real/out_imag valid
out_real  out  15  signed s0.14 result, real part
out_imag  out  15  signed s0.14 result, imag part
out_sat  out  1  this output sample was saturated (either part), qualified by out_valid
ovf_count  out  8  number of saturated samples since reset/clear; saturates at 255

Behaviour:
- Reset: asynchronous; all pipeline registers, out_valid, out_real, out_imag, out_sat and ovf_count go to 0 immediately. Any in-flight samples are discarded.
- Stage 1 (cycle N+1): registers valid1 <= in_valid. When in_valid=1, also registers:
  - mode=1: sum_re = multi_real - multi_imag; sum_im = multi_real_imag_1 + multi_real_imag_2.
  - mode=0 (bypass): sum_re = multi_real; sum_im = multi_real_imag_2. multi_imag and multi_real_imag_1 are ignored.
  - Both sums are 29-bit signed, sign-extended from 28 bits; no overflow is possible here.
  - When in_valid=0, the data registers hold their value.
- Stage 2 (cycle N+2), per part:
  - r = (sum + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed at 30 bits (round half up, arithmetic shift).
  - Saturate r to [-16384, 16383]. out_sat = 1 if either part clipped.
  - out_valid <= valid1. Output data registers load only when valid1=1 and hold otherwise.
- Latency: exactly 2 clocks, in_valid to out_valid. Full throughput, one sample per clock, no backpressure. Bubbles propagate unchanged.
- ovf_count:
  - Increments by 1 on each cycle with valid1=1 and a saturation. Sticks at 255.
  - ovf_clr=1 forces it to 0 and takes priority over a simultaneous increment.
- out_sat is meaningful only when out_valid=1. It is 0 after reset.

Test Plan:
- Multiply by 1: mode=1, multi_real=16777216, multi_imag=0, ri1=0, ri2=8388608 -> 2 clocks later out_valid=1, out_real=8192, out_imag=4096, out_sat=0.
- Multiply by -j: mode=1, multi_real=0, multi_imag=-8388608, ri1=-16777216, ri2=0 -> out_real=4096, out_imag=-8192.
- Rounding: multi_real=1024 -> out_real=1; 1023 -> 0; -1024 -> 0; -1025 -> -1 (other inputs 0, mode=1).
- Saturation: mode=1, multi_real=33554432, multi_imag=-33554432, ri1=ri2=0 -> out_real=16383, out_sat=1, ovf_count 0->1. Repeat 300 times -> ovf_count=255; ovf_clr asserted in the same cycle as an overflow -> 0.
- Bypass: mode=0, multi_real=-16777216, multi_imag=12345678, ri1=999, ri2=2048 -> out_real=-8192, out_imag=1 (garbage products ignored). A back-to-back stream with alternating in_valid -> the out_valid pattern repeats delayed by exactly 2 clocks.
- Reset mid-stream: assert rst asynchronously with 2 samples in flight -> all outputs 0 immediately. No stale out_valid after release. The first new sample appears 2 clocks after its in_valid.

Source files
------------

// File: rtl/s4_twiddle_combiner.sv
// Stage-4 twiddle combiner: forms the complex product from four raw partial
// products, rounds it to s0.14 with saturation, and presents a registered sample.
module s4_twiddle_combiner #(
  parameter int IN_W       = 28,
  parameter int OUT_W      = 15,
  parameter int FRAC_SHIFT = 11,
  parameter int OVF_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    multi_stage,
  input  logic signed [IN_W-1:0]  multi_real,
  input  logic signed [IN_W-1:0]  multi_imag,
  input  logic signed [IN_W-1:0]  multi_real_imag_1,
  input  logic signed [IN_W-1:0]  multi_real_imag_2,
  input  logic                    ovf_clr,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_real,
  output logic signed [OUT_W-1:0] out_imag,
  output logic                    out_sat,
  output logic [OVF_W-1:0]        ovf_count
);

  localparam int SUM_W = IN_W + 1;
  localparam int RND_W = IN_W + 2;

  localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RND_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic signed [RND_W-1:0] ROUND   = RND_W'(2 ** (FRAC_SHIFT - 1));
  localparam logic [OVF_W-1:0]        OVF_MAX = '1;

  typedef struct packed {
    logic signed [OUT_W-1:0] val;
    logic                    sat;
  } quant_t;

  // Round half up, drop the twiddle fraction bits, then clip to the s0.14 range.
  function automatic quant_t requant(input logic signed [SUM_W-1:0] s);
    logic signed [RND_W-1:0] r;
    quant_t                  q;
    r = {{(RND_W - SUM_W){s[SUM_W-1]}}, s};
    r = (r + ROUND) >>> FRAC_SHIFT;
    if (r > OUT_MAX) begin
      q.val = OUT_MAX[OUT_W-1:0];
      q.sat = 1'b1;
    end else if (r < OUT_MIN) begin
      q.val = OUT_MIN[OUT_W-1:0];
      q.sat = 1'b1;
    end else begin
      q.val = r[OUT_W-1:0];
      q.sat = 1'b0;
    end
    return q;
  endfunction

  // Stage 1 state
  logic                    valid1_q, valid1_d;
  logic signed [SUM_W-1:0] sum_re_q, sum_re_d;
  logic signed [SUM_W-1:0] sum_im_q, sum_im_d;

  // Stage 2 state
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_real_q,  out_real_d;
  logic signed [OUT_W-1:0] out_imag_q,  out_imag_d;
  logic                    out_sat_q,   out_sat_d;
  logic [OVF_W-1:0]        ovf_count_q, ovf_count_d;

  logic signed [SUM_W-1:0] re_x, im_x, ri1_x, ri2_x;
  quant_t                  q_re, q_im;
  logic                    sat_any;

  assign re_x  = {multi_real[IN_W-1],        multi_real};
  assign im_x  = {multi_imag[IN_W-1],        multi_imag};
  assign ri1_x = {multi_real_imag_1[IN_W-1], multi_real_imag_1};
  assign ri2_x = {multi_real_imag_2[IN_W-1], multi_real_imag_2};

  assign q_re    = requant(sum_re_q);
  assign q_im    = requant(sum_im_q);
  assign sat_any = q_re.sat | q_im.sat;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned
    // and no latch is inferred.
    valid1_d    = in_valid;
    sum_re_d    = sum_re_q;
    sum_im_d    = sum_im_q;
    out_valid_d = valid1_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    out_sat_d   = out_sat_q;
    ovf_count_d = ovf_count_q;

    if (in_valid) begin
      if (multi_stage) begin
        sum_re_d = re_x - im_x;
        sum_im_d = ri1_x + ri2_x;
      end else begin
        sum_re_d = re_x;
        sum_im_d = ri2_x;
      end
    end

    if (valid1_q) begin
      out_real_d = q_re.val;
      out_imag_d = q_im.val;
      out_sat_d  = sat_any;
    end

    // Clear wins over a same-cycle overflow event.
    if (ovf_clr) begin
      ovf_count_d = '0;
    end else if (valid1_q && sat_any && ovf_count_q != OVF_MAX) begin
      ovf_count_d = ovf_count_q + OVF_W'(1);
    end
  end

  // NOTE: data registers are plain flops, not a memory, so they are cleared on
  // reset along with the valids; stale data never leaks out after a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_q    <= 1'b0;
      sum_re_q    <= '0;
      sum_im_q    <= '0;
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_sat_q   <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      valid1_q    <= valid1_d;
      sum_re_q    <= sum_re_d;
      sum_im_q    <= sum_im_d;
      out_valid_q <= out_valid_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      out_sat_q   <= out_sat_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign out_sat   = out_sat_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_s4_twiddle_combiner.sv
// Directed bench for s4_twiddle_combiner: hand-computed vectors for product,
// rounding, saturation, overflow counting, bypass, valid pipelining and reset.
module tb_s4_twiddle_combiner;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               multi_stage = 1'b0;
  logic signed [27:0] mr = '0, mi = '0, ri1 = '0, ri2 = '0;
  logic               ovf_clr = 1'b0;
  logic               out_valid;
  logic signed [14:0] out_real, out_imag;
  logic               out_sat;
  logic [7:0]         ovf_count;

  int n_total = 0;
  int n_bad   = 0;

  s4_twiddle_combiner dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .multi_stage       (multi_stage),
    .multi_real        (mr),
    .multi_imag        (mi),
    .multi_real_imag_1 (ri1),
    .multi_real_imag_2 (ri2),
    .ovf_clr           (ovf_clr),
    .out_valid         (out_valid),
    .out_real          (out_real),
    .out_imag          (out_imag),
    .out_sat           (out_sat),
    .ovf_count         (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic m, input int a, input int b, input int c, input int d);
    in_valid    = v;
    multi_stage = m;
    mr  = a[27:0];
    mi  = b[27:0];
    ri1 = c[27:0];
    ri2 = d[27:0];
  endtask

  // One isolated sample: inputs at a falling edge, result two rising edges later.
  task automatic run_one(input string tag, input logic m, input int a, input int b, input int c, input int d,
                         input int exp_re, input int exp_im, input int exp_sat);
    @(negedge clk);
    set_in(1'b1, m, a, b, c, d);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_re"},    out_real,  exp_re);
    chk({tag, "_im"},    out_imag,  exp_im);
    chk({tag, "_sat"},   out_sat,   exp_sat);
  endtask

  localparam int P24 = 16777216;
  localparam int P23 = 8388608;
  localparam int P25 = 33554432;

  logic [11:0] pat;

  initial begin
    #3 rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_re",    out_real,  0);
    chk("rst_im",    out_imag,  0);
    chk("rst_sat",   out_sat,   0);
    chk("rst_ovf",   ovf_count, 0);
    @(negedge clk);
    rst = 1'b0;

    run_one("mul1",   1'b1, P24, 0, 0, P23, 8192, 4096, 0);
    run_one("mulnj",  1'b1, 0, -P23, -P24, 0, 4096, -8192, 0);
    run_one("rnd1024",  1'b1,  1024, 0, 0, 0,  1, 0, 0);
    run_one("rnd1023",  1'b1,  1023, 0, 0, 0,  0, 0, 0);
    run_one("rndm1024", 1'b1, -1024, 0, 0, 0,  0, 0, 0);
    run_one("rndm1025", 1'b1, -1025, 0, 0, 0, -1, 0, 0);
    run_one("bypass", 1'b0, -P24, 12345678, 999, 2048, -8192, 1, 0);
    chk("ovf_pre", ovf_count, 0);

    run_one("satp", 1'b1, P25, -P25, 0, 0, 16383, 0, 1);
    chk("ovf_1", ovf_count, 1);
    run_one("satn", 1'b1, -P25, P25, 0, 0, -16384, 0, 1);
    chk("ovf_2", ovf_count, 2);
    run_one("sati", 1'b1, 0, 0, P25, P25, 0, 16383, 1);
    chk("ovf_3", ovf_count, 3);

    // 297 more back-to-back overflows take the count past 255.
    for (int i = 0; i < 297; i++) begin
      @(negedge clk);
      set_in(1'b1, 1'b1, P25, -P25, 0, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ovf_stick", ovf_count, 255);

    // Clear coincides with the edge that would count an overflow.
    @(negedge clk);
    set_in(1'b1, 1'b1, P25, -P25, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    ovf_clr  = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("clr_ovf", ovf_count, 0);
    chk("clr_sat", out_sat, 1);
    run_one("satpost", 1'b1, P25, -P25, 0, 0, 16383, 0, 1);
    chk("ovf_after_clr", ovf_count, 1);

    // Alternating valid stream in bypass; bubbles carry different data.
    pat = 12'b0000_0100_1101;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 2) chk($sformatf("pat_valid%0d", i), out_valid, pat[i-2]);
      if (pat[i]) set_in(1'b1, 1'b0, -P24, 12345678, 999, 2048);
      else        set_in(1'b0, 1'b1, P24, 0, 0, P23);
    end
    chk("hold_re", out_real, -8192);
    chk("hold_im", out_imag, 1);

    // Reset with two samples in flight.
    @(negedge clk);
    set_in(1'b1, 1'b1, P24, 0, 0, P23);
    @(negedge clk);
    set_in(1'b1, 1'b1, P25, -P25, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_ovf",   ovf_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_re",    out_real,  0);
    chk("mid_rst_im",    out_imag,  0);
    chk("mid_rst_sat",   out_sat,   0);
    chk("mid_rst_ovf",   ovf_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid1", out_valid, 0);
    @(negedge clk);
    chk("post_rst_valid2", out_valid, 0);
    chk("post_rst_ovf",    ovf_count, 0);
    run_one("post_rst", 1'b1, 0, -P23, -P24, 0, 4096, -8192, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
